// File: rtl/dwt2d_tile_sched_if.sv
// Bundle of the scheduler's control, tile-memory and 1-D core stream signals.
// master: the scheduler (dwt2d_tile_sched).
// slave : the environment (tile memory, 1-D lifting core, controller).
//   start/busy/done/err             control and status
//   rd_en/rd_addr/rd_data           tile memory read port (1-cycle read latency)
//   wr_en/wr_addr/wr_data           tile memory write port
//   core_in_*                       feed stream to the 1-D core
//   core_out_*                      result stream from the 1-D core
interface dwt2d_tile_sched_if #(
   parameter int DataWidth = 16,
   parameter int SideSize  = 16,
   parameter int AddrWidth = 2*$clog2(SideSize)
);
   logic                 start, busy, done, err;
   logic                 rd_en;
   logic [AddrWidth-1:0] rd_addr;
   logic [DataWidth-1:0] rd_data;
   logic                 wr_en;
   logic [AddrWidth-1:0] wr_addr;
   logic [DataWidth-1:0] wr_data;
   logic                 core_in_valid, core_in_ready, core_in_last;
   logic [DataWidth-1:0] core_in_data;
   logic                 core_out_valid, core_out_ready, core_out_last;
   logic [DataWidth-1:0] core_out_data;

   modport master (
      input  start, rd_data, core_in_ready, core_out_valid, core_out_data, core_out_last,
      output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data,
             core_in_valid, core_in_data, core_in_last, core_out_ready
   );
   modport slave (
      output start, rd_data, core_in_ready, core_out_valid, core_out_data, core_out_last,
      input  busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data,
             core_in_valid, core_in_data, core_in_last, core_out_ready
   );
endinterface

// File: rtl/dwt2d_tile_sched.sv
// One level of the 2-D 9/7 DWT over an N x N tile: streams every row, then
// every column, through the shared 1-D core and writes each result line back
// in place, deinterleaved (low half first, high half second).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  dwt2d_tile_sched_if.master (control, tile memory ports, core streams)
module dwt2d_tile_sched #(
   parameter int DataWidth = 16,
   parameter int SideSize  = 16,
   parameter int AddrWidth = 2*$clog2(SideSize)
) (
   input logic                clk,
   input logic                rst,
   dwt2d_tile_sched_if.master bus
);
   localparam int            LW   = $clog2(SideSize);
   localparam logic [LW-1:0] LAST = LW'(SideSize-1);

   typedef enum logic [2:0] {IDLE, ROW, ROW_WAIT, COL, COL_WAIT} state_t;
   state_t state, state_nx;

   // fl is one bit wider so it can sit at N once a pass is fully read,
   // which releases the write side for the last line.
   logic [LW:0]          fl;
   logic [LW-1:0]        fi, oi, k, w;
   logic                 rd_inflight;
   logic [DataWidth-1:0] fifo [2];
   logic                 wp, rp;
   logic [1:0]           occ;
   logic                 done_q, err_q;

   logic start_ok, feeding, rd_fire, feed_end;
   logic in_valid, in_fire, push, pop;
   logic out_ready, wr_fire, pass_end, col_wr;
   logic [LW-1:0]        pos;
   logic [DataWidth-1:0] in_data;
   logic [AddrWidth-1:0] rd_addr_raw, wr_addr_raw;

   assign start_ok = (state == IDLE) && bus.start;
   assign feeding  = (state == ROW) || (state == COL);
   // Issue a read only if the 2-entry buffer can absorb it even if the core stalls.
   assign rd_fire  = feeding && ((occ + {1'b0, rd_inflight}) < 2'd2);
   assign feed_end = (fl[LW-1:0] == LAST) && (fi == LAST);

   // Empty buffer bypass: returning read data goes straight to the core.
   assign in_valid = (occ != 2'd0) || rd_inflight;
   assign in_data  = (occ != 2'd0) ? fifo[rp] : bus.rd_data;
   assign in_fire  = in_valid && bus.core_in_ready;
   assign push     = rd_inflight && !((occ == 2'd0) && bus.core_in_ready);
   assign pop      = in_fire && (occ != 2'd0);

   // pos(k) = k/2 (even) or N/2 + k/2 (odd) is a rotate of k by one bit.
   assign pos       = {k[0], k[LW-1:1]};
   assign col_wr    = (state == COL) || (state == COL_WAIT);
   // Line w may only be overwritten once the feed has read all of it.
   assign out_ready = (state != IDLE) && (fl > {1'b0, w});
   assign wr_fire   = bus.core_out_valid && out_ready;
   assign pass_end  = wr_fire && (w == LAST) && (k == LAST);

   assign rd_addr_raw = (state == COL) ? {fi, fl[LW-1:0]} : {fl[LW-1:0], fi};
   assign wr_addr_raw = col_wr ? {pos, w} : {w, pos};

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (bus.start)           state_nx = ROW;
         ROW:      if (rd_fire && feed_end) state_nx = ROW_WAIT;
         ROW_WAIT: if (pass_end)            state_nx = COL;
         COL:      if (rd_fire && feed_end) state_nx = COL_WAIT;
         COL_WAIT: if (pass_end)            state_nx = IDLE;
         default:                           state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         fl          <= '0;
         fi          <= '0;
         oi          <= '0;
         k           <= '0;
         w           <= '0;
         rd_inflight <= 1'b0;
         wp          <= 1'b0;
         rp          <= 1'b0;
         occ         <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state       <= state_nx;
         rd_inflight <= rd_fire;
         done_q      <= (state == COL_WAIT) && pass_end;
         if (start_ok) begin
            fl    <= '0;
            fi    <= '0;
            oi    <= '0;
            k     <= '0;
            w     <= '0;
            wp    <= 1'b0;
            rp    <= 1'b0;
            occ   <= '0;
            err_q <= 1'b0;
         end else begin
            if (rd_fire) begin
               fi <= fi + 1'b1;
               if (fi == LAST) fl <= fl + 1'b1;
            end else if ((state == ROW_WAIT) && pass_end) begin
               fl <= '0;
               fi <= '0;
            end
            if (in_fire) oi <= oi + 1'b1;
            // Counters track k; core_out_last only feeds the error flag.
            if (wr_fire) begin
               k <= k + 1'b1;
               if (k == LAST) w <= w + 1'b1;
               if (bus.core_out_last != (k == LAST)) err_q <= 1'b1;
            end
            if (push) wp <= ~wp;
            if (pop)  rp <= ~rp;
            occ <= occ + {1'b0, push} - {1'b0, pop};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo[wp] <= bus.rd_data;
   end

   assign bus.busy           = (state != IDLE);
   assign bus.done           = done_q;
   assign bus.err            = err_q;
   assign bus.rd_en          = rd_fire;
   assign bus.rd_addr        = rd_fire ? rd_addr_raw : '0;
   assign bus.core_in_valid  = in_valid;
   assign bus.core_in_data   = in_valid ? in_data : '0;
   assign bus.core_in_last   = in_valid && (oi == LAST);
   assign bus.core_out_ready = out_ready;
   assign bus.wr_en          = wr_fire;
   assign bus.wr_addr        = wr_fire ? wr_addr_raw : '0;
   assign bus.wr_data        = wr_fire ? bus.core_out_data : '0;
endmodule

// File: tb/tb_dwt2d_tile_sched.sv
module tb_dwt2d_tile_sched;
   localparam int DW = 16, N = 16, AW = 8, NN = 256, LAT = 3;
   localparam int OW = 3 + 1 + AW + 1 + AW + DW + 1 + DW + 1 + 1;
   localparam int DONE_LAT = 545;  // cycles from accepted start to done, identity core, no stalls

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dwt2d_tile_sched_if #(.DataWidth(DW), .SideSize(N), .AddrWidth(AW)) bus ();
   dwt2d_tile_sched #(.DataWidth(DW), .SideSize(N), .AddrWidth(AW)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int checks = 0, errors = 0;

   logic [DW-1:0] mem        [NN];
   logic [DW-1:0] init_mem   [NN];
   logic [DW-1:0] rowres     [NN];
   logic [DW-1:0] expect_mem [NN];
   logic ld_all = 1'b0, mon_clr = 1'b0, flush = 1'b0;
   bit   rnd_mode = 1'b0, inj = 1'b0;

   logic          s_in_hs = 1'b0, s_in_l = 1'b0, s_out_hs = 1'b0;
   logic [DW-1:0] s_in_d = '0;
   int pc = 0, rd15 = -1, first_wr = -1, held = 0, done_cnt = 0;

   wire [OW-1:0] all_out = {bus.busy, bus.done, bus.err, bus.rd_en, bus.rd_addr, bus.wr_en,
                            bus.wr_addr, bus.wr_data, bus.core_in_valid, bus.core_in_data,
                            bus.core_in_last, bus.core_out_ready};

   // Tile memory, handshake sampling and hazard monitor.
   always @(posedge clk) begin
      pc <= pc + 1;
      if (ld_all) begin
         for (int i = 0; i < NN; i++) mem[i] <= init_mem[i];
      end else if (bus.wr_en) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
      s_in_hs  <= bus.core_in_valid & bus.core_in_ready;
      s_in_d   <= bus.core_in_data;
      s_in_l   <= bus.core_in_last;
      s_out_hs <= bus.core_out_valid & bus.core_out_ready;
      if (mon_clr) begin
         rd15 <= -1; first_wr <= -1; held <= 0; done_cnt <= 0;
      end else begin
         if (bus.rd_en && bus.rd_addr == 8'd15 && rd15 < 0) rd15 <= pc;
         if (bus.wr_en && first_wr < 0) first_wr <= pc;
         if (bus.core_out_valid && !bus.core_out_ready && bus.busy && first_wr < 0) held <= held + 1;
         if (bus.done) done_cnt <= done_cnt + 1;
      end
   end

   function automatic int pos(input int kk);
      return (kk % 2) ? N/2 + kk/2 : kk/2;
   endfunction

   // Reference: row pass deinterleaves each row, column pass each column.
   task automatic compute_ref();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) rowres[r*N + pos(c)] = init_mem[r*N + c];
      for (int c = 0; c < N; c++)
         for (int r = 0; r < N; r++) expect_mem[pos(r)*N + c] = rowres[r*N + c];
   endtask

   function automatic logic [DW-1:0] exp_feed(input int j);
      int m;
      if (j < NN) return init_mem[j];
      m = j - NN;
      return rowres[(m % N)*N + m / N];
   endfunction

   // Identity 1-D core model with LAT cycles latency and optional random stalls.
   logic [DW-1:0] cq_d[$];
   bit            cq_l[$];
   int            cq_t[$];
   int cyc = 0, in_cnt = 0, out_cnt = 0, feed_bad = 0, last_bad = 0;
   bit showing = 1'b0;
   initial begin
      bus.core_in_ready = 1'b0; bus.core_out_valid = 1'b0;
      bus.core_out_data = '0;   bus.core_out_last  = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (flush) begin
            cq_d.delete(); cq_l.delete(); cq_t.delete();
            showing = 1'b0; in_cnt = 0; out_cnt = 0; feed_bad = 0; last_bad = 0;
         end else begin
            if (s_in_hs) begin
               if (s_in_d !== exp_feed(in_cnt % (2*NN))) feed_bad++;
               if (s_in_l !== ((in_cnt % N) == N-1)) last_bad++;
               cq_d.push_back(s_in_d); cq_l.push_back(s_in_l); cq_t.push_back(cyc);
               in_cnt++;
            end
            if (s_out_hs && cq_d.size() > 0) begin
               void'(cq_d.pop_front()); void'(cq_l.pop_front()); void'(cq_t.pop_front());
               out_cnt++;
               showing = 1'b0;
            end
         end
         bus.core_in_ready = rnd_mode ? ($urandom % 2 == 1) : 1'b1;
         if (!showing && cq_d.size() > 0 && (cyc - cq_t[0]) >= LAT-1 &&
             (!rnd_mode || $urandom % 2 == 1)) showing = 1'b1;
         bus.core_out_valid = showing;
         bus.core_out_data  = showing ? cq_d[0] : '0;
         bus.core_out_last  = showing ? (cq_l[0] | (inj && (out_cnt % (2*NN)) == 3*N + 14)) : 1'b0;
      end
   end

   task automatic prep(input bit random_data);
      for (int i = 0; i < NN; i++) init_mem[i] = random_data ? DW'($urandom) : DW'(i);
      compute_ref();
      ld_all = 1'b1; mon_clr = 1'b1; flush = 1'b1;
      @(negedge clk);
      ld_all = 1'b0;
      @(negedge clk);
      mon_clr = 1'b0; flush = 1'b0;
   endtask

   task automatic wait_done(input string name, input int bound, inout int n);
      while (bus.done !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (bus.done !== 1'b1) begin
         checks++; errors++;
         $display("FAIL %s_timeout no done after %0d cycles", name, n);
      end
   endtask

   task automatic check_mem(input string name);
      int bad = 0;
      for (int i = 0; i < NN; i++) if (mem[i] !== expect_mem[i]) bad++;
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL %s_mem %0d words differ, want 0", name, bad); end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_out); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL idle_outputs got %h want 0", all_out); end
   endtask

   task automatic test_identity();
      int n;
      rnd_mode = 1'b0; inj = 1'b0;
      prep(1'b0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      checks++;
      if ({bus.busy, bus.rd_en, bus.rd_addr} !== {1'b1, 1'b1, 8'd0}) begin
         errors++; $display("FAIL first_read got busy/rd_en/addr %b %b %0d want 1 1 0",
                            bus.busy, bus.rd_en, bus.rd_addr);
      end
      @(negedge clk);
      n++;
      checks++;
      if ({bus.core_in_valid, bus.core_in_data} !== {1'b1, 16'd0}) begin
         errors++; $display("FAIL first_feed got valid %b data %0d want 1 0",
                            bus.core_in_valid, bus.core_in_data);
      end
      wait_done("identity", 3000, n);
      checks++;
      if (n !== DONE_LAT) begin errors++; $display("FAIL done_latency got %0d want %0d", n, DONE_LAT); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b want 0", bus.busy); end
      @(negedge clk);
      checks++;
      if (mem[8] !== 16'd1 || mem[136] !== 16'd17 || mem[0] !== 16'd0 || mem[255] !== 16'd255) begin
         errors++; $display("FAIL spot_words got %0d %0d %0d %0d want 1 17 0 255",
                            mem[8], mem[136], mem[0], mem[255]);
      end
      check_mem("identity");
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL identity_err got %b want 0", bus.err); end
      checks++;
      if (feed_bad !== 0 || last_bad !== 0 || in_cnt !== 2*NN) begin
         errors++; $display("FAIL identity_feed got bad %0d last_bad %0d count %0d want 0 0 %0d",
                            feed_bad, last_bad, in_cnt, 2*NN);
      end
      checks++;
      if (!(first_wr > rd15 && rd15 >= 0 && held > 0)) begin
         errors++; $display("FAIL hazard got first_wr %0d rd15 %0d held %0d want first_wr>rd15, held>0",
                            first_wr, rd15, held);
      end
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 2; it++) begin
         rnd_mode = 1'b1; inj = 1'b0;
         prep(1'b1);
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
         n = 1;
         wait_done("random", 20000, n);
         @(negedge clk);
         check_mem("random");
         checks++;
         if (feed_bad !== 0 || last_bad !== 0 || in_cnt !== 2*NN) begin
            errors++; $display("FAIL random_feed got bad %0d last_bad %0d count %0d want 0 0 %0d",
                               feed_bad, last_bad, in_cnt, 2*NN);
         end
         checks++;
         if (bus.err !== 1'b0) begin errors++; $display("FAIL random_err got %b want 0", bus.err); end
      end
      rnd_mode = 1'b0;
   endtask

   task automatic test_err();
      int n;
      inj = 1'b1;
      prep(1'b0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      wait_done("err", 3000, n);
      repeat (5) @(negedge clk);
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus.err); end
      check_mem("err");
      inj = 1'b0;
      prep(1'b0);
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL err_hold_idle got %b want 1", bus.err); end
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", bus.err); end
      n = 1;
      wait_done("err_clean", 3000, n);
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clean_run got %b want 0", bus.err); end
   endtask

   task automatic test_reset_mid();
      int n;
      prep(1'b0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (400) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL midcol_reset got %h want 0", all_out); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL post_reset_idle got %h want 0", all_out); end
      prep(1'b0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if ({bus.rd_en, bus.rd_addr} !== {1'b1, 8'd0}) begin
         errors++; $display("FAIL restart_addr got %b %0d want 1 0", bus.rd_en, bus.rd_addr);
      end
      n = 1;
      wait_done("restart", 3000, n);
      @(negedge clk);
      check_mem("restart");
   endtask

   task automatic test_back_to_back();
      int n;
      prep(1'b0);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      while (bus.done !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
         bus.start = (n == 50 || n == 300);
      end
      checks++;
      if (n !== DONE_LAT) begin errors++; $display("FAIL busy_start_latency got %0d want %0d", n, DONE_LAT); end
      // Restart in the done cycle on the already transformed tile.
      for (int i = 0; i < NN; i++) init_mem[i] = expect_mem[i];
      compute_ref();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (done_cnt !== 1) begin errors++; $display("FAIL done_once got %0d want 1", done_cnt); end
      checks++;
      if ({bus.busy, bus.rd_en} !== 2'b11) begin
         errors++; $display("FAIL b2b_accept got busy %b rd_en %b want 1 1", bus.busy, bus.rd_en);
      end
      n = 1;
      wait_done("b2b", 3000, n);
      @(negedge clk);
      check_mem("b2b");
      checks++;
      if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
   endtask

   initial begin
      bus.start = 1'b0;
      test_reset();
      test_identity();
      test_random();
      test_err();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dwt2d_tile_sched.md
# dwt2d_tile_sched

Sequencer for one level of the 2-D 9/7 DWT on a square tile held in a dual-port tile memory. It streams every row, then every column, of the tile through the shared 1-D lifting core. It writes each core output line back into the tile in place, deinterleaved: low-pass half first, high-pass half second. The block sits between the tile buffer (one read port, one write port) and the 1-D DWT core's input and output streams. Data is passed through untouched, as 16-bit fixed point with 10 fractional bits.

## Interface
- DataWidth, 16, sample width in bits (fixed point, 10 fractional bits; never inspected)
- SideSize, 16, tile side N; power of two, ≥4
- AddrWidth, 2*$clog2(SideSize), tile memory address width; address = row*N + col
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to transform the tile; ignored unless IDLE
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last column-pass write
- err  out  1  sticky line-length mismatch flag; cleared by accepted start or rst
- rd_en  out  1  tile memory read strobe
- rd_addr  out  AddrWidth  read address
- rd_data  in  DataWidth  read data, valid exactly 1 cycle after rd_en
- wr_en  out  1  tile memory write strobe
- wr_addr  out  AddrWidth  write address
- wr_data  out  DataWidth  write data
- core_in_valid / core_in_ready  out / in  1  feed handshake to the 1-D core
- core_in_data  out  DataWidth  sample to the core
- core_in_last  out  1  high on sample N-1 of each line
- core_out_valid / core_out_ready  in / out  1  result handshake from the core
- core_out_data  in  DataWidth  core result; interleaved L0,H0,L1,H1,…
- core_out_last  in  1  core marks the last result of a line

## Operation
- States: IDLE → ROW → ROW_WAIT → COL → COL_WAIT → IDLE (done pulses on the COL_WAIT→IDLE transition).
- Feed side (ROW/COL): walks line l = 0..N-1 and index i = 0..N-1. It reads row addr l*N+i in ROW, and column addr i*N+l in COL.
  - Read data goes through a 2-entry buffer to the core_in stream, so nothing is lost under backpressure.
  - A read is issued only if the buffer has a free slot after counting in-flight reads.
  - After issuing the last read of a pass, the feed side goes to the corresponding _WAIT state.
- Write side: counts output index k and line w for the current pass.
  - pos(k) = k/2 for even k, N/2 + k/2 for odd k.
  - Write address is w*N+pos(k) in the row pass and pos(k)*N+w in the column pass.
  - wr_data = core_out_data; wr_en = core_out_valid & core_out_ready.
- In-place hazard rule: core_out_ready is held low while the feed line counter ≤ w, so line w is written only after all of it has been read. Otherwise ready is high.
- Pass switch: ROW_WAIT → COL only after the row-pass write of (w=N-1, k=N-1). The column pass never reads stale rows.
- If core_out_last ≠ (k==N-1) on an accepted output, err is set. The counters still follow k, not core_out_last.
- start while busy: ignored, no effect on err.
- rst (any state, mid-pass included): state IDLE; all counters and the buffer cleared; in-flight read data discarded. Outputs go to 0.

## Timing
- Reset value of every output: 0.
- Accepted start at cycle t: busy=1 and first rd_en at t+1; first core_in_valid at t+2.
- With core_in_ready held high, the feed runs at one read and one sample per cycle with no bubbles across lines. Between passes the feed idles until the last row write.
- The write side is combinational from core_out_valid, with zero added latency.
- done=1 and busy=0 in the cycle after the final write; a new start is accepted in that same cycle.

## Test plan
- Identity core (out=in, 3-cycle latency, always ready), mem[a]=a, start → after done: mem[8]=1, mem[136]=17, mem[0]=0, mem[255]=255 (orig 255 → row pos(15)=15, col 15); err=0.
- Same setup with core_in_ready and core_out_valid each randomly 50% → identical final memory; no rd_data lost or duplicated; core_in_last on every 16th sample.
- Core emits line 0 results before line 0 is fully fed → core_out_ready stays 0 until feed line=1; no write to row 0 before read of addr 15.
- Core asserts core_out_last on k=14 of line 3 → err=1 and stays 1 until the next start; final memory still matches identity layout.
- rst asserted mid-COL → next cycle all outputs 0, state IDLE; new start runs cleanly (first rd_addr=0).
- start pulsed while busy → no restart; done is pulsed exactly once, at t+2*256+pipeline overhead.
